// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the register-address type.
package cpu_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t XZR_IDX = reg_addr_t'(REG_COUNT - 1);
endpackage

// File: rtl/regfile.sv
// 32 x N register file: two combinational read ports, one write port, X31 reads as zero.
// Define REGFILE_BYPASS_EN to forward write data onto the read ports in the same cycle.
module regfile
  import cpu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  reg_addr_t     ra1,
  input  reg_addr_t     ra2,
  input  logic          we3,
  input  reg_addr_t     wa3,
  input  logic [N-1:0]  wd3,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2
);

  logic [N-1:0] regs [REG_COUNT];

  // Reset preloads X[i] = i; the XZR slot stays zero and is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == int'(XZR_IDX)) ? '0 : N'(i);
      end
    end else if (we3 && (wa3 != XZR_IDX)) begin
      regs[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!reset) begin
      // During reset the ports echo the address, matching the preload values.
      rd1 = (ra1 == XZR_IDX) ? '0 : N'(ra1);
      rd2 = (ra2 == XZR_IDX) ? '0 : N'(ra2);
    end else begin
      if (ra1 != XZR_IDX) rd1 = regs[ra1];
      if (ra2 != XZR_IDX) rd2 = regs[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we3 && (wa3 != XZR_IDX) && (ra1 == wa3)) rd1 = wd3;
      if (we3 && (wa3 != XZR_IDX) && (ra2 == wa3)) rd2 = wd3;
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile (N = 64); expectations follow REGFILE_BYPASS_EN.
module tb_regfile;
  import cpu_pkg::*;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  reg_addr_t    ra1, ra2, wa3;
  logic         we3;
  logic [N-1:0] wd3;
  logic [N-1:0] rd1, rd2;

  int checks   = 0;
  int failures = 0;

  regfile #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .we3   (we3),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply a write for exactly one rising edge, then drop we3.
  task automatic write_reg(input reg_addr_t a, input logic [N-1:0] d);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    @(posedge clk);
    #1;
    we3 = 1'b0;
  endtask

  task automatic read_pair(input reg_addr_t a1, input reg_addr_t a2);
    ra1 = a1;
    ra2 = a2;
    #1;
  endtask

  logic [N-1:0] exp_same;

  initial begin
    reset = 1'b1;
    we3   = 1'b0;
    wa3   = '0;
    wd3   = '0;
    ra1   = '0;
    ra2   = '0;
    #2;
    reset = 1'b0;
    #1;

    // Reset read-back echoes the address.
    read_pair(5'd5, 5'd30);
    check("rst_rd1_x5", rd1, 64'd5);
    check("rst_rd2_x30", rd2, 64'd30);
    read_pair(5'd31, 5'd0);
    check("rst_rd1_xzr", rd1, 64'd0);
    check("rst_rd2_x0", rd2, 64'd0);

    // A write presented at an edge during reset is blocked.
    write_reg(5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    read_pair(5'd5, 5'd6);
    check("rst_blocked_x5", rd1, 64'd5);

    // Release between edges; the first edge after release must accept a write.
    @(negedge clk);
    reset = 1'b1;
    #1;
    read_pair(5'd5, 5'd30);
    check("post_rst_x5", rd1, 64'd5);
    check("post_rst_x30", rd2, 64'd30);
    write_reg(5'd3, 64'hDEADBEEF_CAFEF00D);
    read_pair(5'd3, 5'd4);
    check("wr_x3", rd1, 64'hDEADBEEF_CAFEF00D);
    check("x4_untouched", rd2, 64'd4);

    // Identical addresses yield identical data.
    read_pair(5'd3, 5'd3);
    check("same_addr_rd1", rd1, 64'hDEADBEEF_CAFEF00D);
    check("same_addr_rd2", rd2, 64'hDEADBEEF_CAFEF00D);

    // Writes to XZR are dropped.
    write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    read_pair(5'd30, 5'd31);
    check("xzr_rd2", rd2, 64'd0);
    check("xzr_x30", rd1, 64'd30);
    read_pair(5'd3, 5'd0);
    check("xzr_x3", rd1, 64'hDEADBEEF_CAFEF00D);
    check("xzr_x0", rd2, 64'd0);

    // Same-cycle read of the register being written.
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'h55;
`else
    exp_same = 64'd7;
`endif
    read_pair(5'd7, 5'd7);
    check("x7_before", rd1, 64'd7);
    we3 = 1'b1;
    wa3 = 5'd7;
    wd3 = 64'h55;
    #1;
    check("rw_same_rd1", rd1, exp_same);
    check("rw_same_rd2", rd2, exp_same);
    @(posedge clk);
    #1;
    we3 = 1'b0;
    #1;
    check("rw_after_rd1", rd1, 64'h55);
    check("rw_after_rd2", rd2, 64'h55);

    // A pending write to XZR must never forward.
    we3 = 1'b1;
    wa3 = 5'd31;
    wd3 = 64'hABCD;
    read_pair(5'd31, 5'd6);
    check("xzr_no_fwd", rd1, 64'd0);
    check("xzr_no_fwd_x6", rd2, 64'd6);
    @(posedge clk);
    #1;
    we3 = 1'b0;

    // Disabled write port ignores address and data.
    we3 = 1'b0;
    wa3 = 5'd2;
    wd3 = 64'hFF;
    @(posedge clk);
    #1;
    read_pair(5'd2, 5'd1);
    check("we0_x2", rd1, 64'd2);
    check("we0_x1", rd2, 64'd1);

    // Back-to-back writes to distinct registers.
    write_reg(5'd10, 64'h0123_4567_89AB_CDEF);
    write_reg(5'd11, 64'h8000_0000_0000_0001);
    write_reg(5'd0,  64'h0000_0000_0000_00A5);
    read_pair(5'd10, 5'd11);
    check("b2b_x10", rd1, 64'h0123_4567_89AB_CDEF);
    check("b2b_x11", rd2, 64'h8000_0000_0000_0001);
    read_pair(5'd0, 5'd12);
    check("b2b_x0", rd1, 64'h0000_0000_0000_00A5);
    check("b2b_x12", rd2, 64'd12);

    // Reset mid-operation restores the preload without a clock edge.
    write_reg(5'd9, 64'h1234);
    read_pair(5'd9, 5'd3);
    check("x9_written", rd1, 64'h1234);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_x9", rd1, 64'd9);
    check("mid_rst_x3", rd2, 64'd3);
    we3 = 1'b1;
    wa3 = 5'd9;
    wd3 = 64'hFFFF;
    #1;
    check("mid_rst_no_fwd", rd1, 64'd9);
    @(posedge clk);
    #1;
    we3 = 1'b0;
    check("mid_rst_edge_x9", rd1, 64'd9);
    @(negedge clk);
    reset = 1'b1;
    #1;
    read_pair(5'd9, 5'd10);
    check("rel_x9", rd1, 64'd9);
    check("rel_x10", rd2, 64'd10);
    read_pair(5'd7, 5'd0);
    check("rel_x7", rd1, 64'd7);
    check("rel_x0", rd2, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
